gpio_ctrl32: RTL and testbench

- 32-pin GPIO register bank. It produces the GPIO-side controls of the AFIO32 pin mux: output data, direction, alternate-function select, and pin mode/select.
- It consumes the pin input value that the mux returns.
- Slave on the peripheral register bus with single-cycle request/acknowledge, one access per request.
- Synchronises pin inputs and optionally raises edge-triggered interrupts.

---
 rtl/gpio_pkg.sv | 60 ++++++
 rtl/gpio_sync.sv | 29 ++
 rtl/gpio_ctrl32.sv | 171 +++++++++++++++++
 tb/tb_gpio_ctrl32.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants, register index enum and write-merge helpers for gpio_ctrl32.
// Registers 0x28-0x30 exist only when GPIO_IRQ_EN is defined.
package gpio_pkg;
  localparam int NPINS = 32;
  localparam int AW    = 6;

  localparam logic [AW-1:0] OFF_OUT     = 6'h00;
  localparam logic [AW-1:0] OFF_IN      = 6'h04;
  localparam logic [AW-1:0] OFF_DIR     = 6'h08;
  localparam logic [AW-1:0] OFF_AFC     = 6'h0C;
  localparam logic [AW-1:0] OFF_PM_LO   = 6'h10;
  localparam logic [AW-1:0] OFF_PM_HI   = 6'h14;
  localparam logic [AW-1:0] OFF_PS_LO   = 6'h18;
  localparam logic [AW-1:0] OFF_PS_HI   = 6'h1C;
  localparam logic [AW-1:0] OFF_OUT_SET = 6'h20;
  localparam logic [AW-1:0] OFF_OUT_CLR = 6'h24;
  localparam logic [AW-1:0] OFF_IE_RISE = 6'h28;
  localparam logic [AW-1:0] OFF_IE_FALL = 6'h2C;
  localparam logic [AW-1:0] OFF_IP      = 6'h30;

  typedef enum logic [3:0] {
    REG_OUT, REG_IN, REG_DIR, REG_AFC, REG_PM_LO, REG_PM_HI, REG_PS_LO, REG_PS_HI,
    REG_OUT_SET, REG_OUT_CLR, REG_IE_RISE, REG_IE_FALL, REG_IP, REG_NONE
  } reg_idx_e;

  function automatic reg_idx_e decode(input logic [AW-1:0] addr);
    reg_idx_e idx;
    case ({addr[AW-1:2], 2'b00})
      OFF_OUT:     idx = REG_OUT;
      OFF_IN:      idx = REG_IN;
      OFF_DIR:     idx = REG_DIR;
      OFF_AFC:     idx = REG_AFC;
      OFF_PM_LO:   idx = REG_PM_LO;
      OFF_PM_HI:   idx = REG_PM_HI;
      OFF_PS_LO:   idx = REG_PS_LO;
      OFF_PS_HI:   idx = REG_PS_HI;
      OFF_OUT_SET: idx = REG_OUT_SET;
      OFF_OUT_CLR: idx = REG_OUT_CLR;
`ifdef GPIO_IRQ_EN
      OFF_IE_RISE: idx = REG_IE_RISE;
      OFF_IE_FALL: idx = REG_IE_FALL;
      OFF_IP:      idx = REG_IP;
`endif
      default:     idx = REG_NONE;
    endcase
    return idx;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction
endpackage

// File: rtl/gpio_sync.sv
// N-stage, W-bit input synchroniser; all stages clear on asynchronous reset.
module gpio_sync #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stage_q [N];
  logic [W-1:0] stage_d [N];

  // Shift chain: stage 0 captures the pin, each later stage copies its predecessor.
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < N; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[N-1];
endmodule

// File: rtl/gpio_ctrl32.sv
// 32-pin GPIO register bank driving the AFIO32 mux GPIO controls.
// Define GPIO_IRQ_EN to add edge interrupts (IE_RISE, IE_FALL, IP, irq).
module gpio_ctrl32
  import gpio_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [63:0] PM_RST      = 64'h0,
  parameter logic [63:0] PS_RST      = 64'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata,
  output logic          ack,
  output logic          err,
  input  logic [31:0]   gpio_in,
  output logic [31:0]   gpio_out,
  output logic [31:0]   gpio_dir,
  output logic [31:0]   gpio_afc,
  output logic [63:0]   gpio_pm,
  output logic [63:0]   gpio_ps,
  output logic          irq
);
  logic [31:0] out_q, out_d, dir_q, dir_d, afc_q, afc_d, rdata_q, rdata_d;
  logic [63:0] pm_q, pm_d, ps_q, ps_d;
  logic        ack_q, ack_d, err_q, err_d;
  logic [31:0] sync_s, bmask_s, wbits_s;
  reg_idx_e    idx_s;

  gpio_sync #(.N(SYNC_STAGES), .W(NPINS)) u_sync (
    .clk(clk), .rst(rst), .d(gpio_in), .q(sync_s)
  );

`ifdef GPIO_IRQ_EN
  // Edges are ignored until the synchroniser and prev have seen real pin samples.
  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);
  logic [31:0] ie_rise_q, ie_rise_d, ie_fall_q, ie_fall_d, ip_q, ip_d, prev_q, prev_d;
  logic [2:0]  settle_q, settle_d;
  logic        irq_q, irq_d;
`endif

  always_comb begin
    idx_s   = decode(addr);
    bmask_s = byte_mask(be);
    wbits_s = wdata & bmask_s;
    out_d   = out_q;
    dir_d   = dir_q;
    afc_d   = afc_q;
    pm_d    = pm_q;
    ps_d    = ps_q;
    rdata_d = 32'h0;
    ack_d   = req;
    err_d   = 1'b0;
`ifdef GPIO_IRQ_EN
    ie_rise_d = ie_rise_q;
    ie_fall_d = ie_fall_q;
    ip_d      = ip_q;
`endif
    if (req) begin
      err_d = (idx_s == REG_NONE);
      if (we) begin
        case (idx_s)
          REG_OUT:     out_d = merge(out_q, wdata, bmask_s);
          REG_DIR:     dir_d = merge(dir_q, wdata, bmask_s);
          REG_AFC:     afc_d = merge(afc_q, wdata, bmask_s);
          REG_PM_LO:   pm_d[31:0]  = merge(pm_q[31:0], wdata, bmask_s);
          REG_PM_HI:   pm_d[63:32] = merge(pm_q[63:32], wdata, bmask_s);
          REG_PS_LO:   ps_d[31:0]  = merge(ps_q[31:0], wdata, bmask_s);
          REG_PS_HI:   ps_d[63:32] = merge(ps_q[63:32], wdata, bmask_s);
          REG_OUT_SET: out_d = out_q | wbits_s;
          REG_OUT_CLR: out_d = out_q & ~wbits_s;
`ifdef GPIO_IRQ_EN
          REG_IE_RISE: ie_rise_d = merge(ie_rise_q, wdata, bmask_s);
          REG_IE_FALL: ie_fall_d = merge(ie_fall_q, wdata, bmask_s);
          REG_IP:      ip_d = ip_q & ~wbits_s;
`endif
          default:     out_d = out_q;
        endcase
      end else begin
        case (idx_s)
          REG_OUT:     rdata_d = out_q;
          REG_IN:      rdata_d = sync_s;
          REG_DIR:     rdata_d = dir_q;
          REG_AFC:     rdata_d = afc_q;
          REG_PM_LO:   rdata_d = pm_q[31:0];
          REG_PM_HI:   rdata_d = pm_q[63:32];
          REG_PS_LO:   rdata_d = ps_q[31:0];
          REG_PS_HI:   rdata_d = ps_q[63:32];
`ifdef GPIO_IRQ_EN
          REG_IE_RISE: rdata_d = ie_rise_q;
          REG_IE_FALL: rdata_d = ie_fall_q;
          REG_IP:      rdata_d = ip_q;
`endif
          default:     rdata_d = 32'h0;
        endcase
      end
    end else begin
      err_d = 1'b0;
    end
`ifdef GPIO_IRQ_EN
    // Set after the W1C clear so a coincident new edge wins.
    if (settle_q == SETTLE) begin
      ip_d     = ip_d | (sync_s & ~prev_q & ie_rise_q) | (~sync_s & prev_q & ie_fall_q);
      settle_d = settle_q;
    end else begin
      ip_d     = ip_d;
      settle_d = settle_q + 3'd1;
    end
    prev_d = sync_s;
    irq_d  = |ip_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= 32'h0;
      dir_q   <= 32'h0;
      afc_q   <= 32'h0;
      pm_q    <= PM_RST;
      ps_q    <= PS_RST;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      afc_q   <= afc_d;
      pm_q    <= pm_d;
      ps_q    <= ps_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef GPIO_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_rise_q <= 32'h0;
      ie_fall_q <= 32'h0;
      ip_q      <= 32'h0;
      prev_q    <= 32'h0;
      settle_q  <= 3'd0;
      irq_q     <= 1'b0;
    end else begin
      ie_rise_q <= ie_rise_d;
      ie_fall_q <= ie_fall_d;
      ip_q      <= ip_d;
      prev_q    <= prev_d;
      settle_q  <= settle_d;
      irq_q     <= irq_d;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign gpio_out = out_q;
  assign gpio_dir = dir_q;
  assign gpio_afc = afc_q;
  assign gpio_pm  = pm_q;
  assign gpio_ps  = ps_q;
endmodule

// File: tb/tb_gpio_ctrl32.sv
// Directed bench for gpio_ctrl32 with a register-map model checked every cycle.
module tb_gpio_ctrl32;
  localparam int          S      = 2;
  localparam logic [63:0] PM_R   = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PS_R   = 64'hAAAA_0000_0000_1234;
`ifdef GPIO_IRQ_EN
  localparam bit          HAS_IRQ = 1'b1;
`else
  localparam bit          HAS_IRQ = 1'b0;
`endif

  logic        clk, rst, req, we, ack, err, irq;
  logic [5:0]  addr;
  logic [31:0] wdata, rdata, gpio_in, gpio_out, gpio_dir, gpio_afc;
  logic [3:0]  be;
  logic [63:0] gpio_pm, gpio_ps;

  gpio_ctrl32 #(.SYNC_STAGES(S), .PM_RST(PM_R), .PS_RST(PS_R)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata), .ack(ack), .err(err), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_dir(gpio_dir), .gpio_afc(gpio_afc), .gpio_pm(gpio_pm), .gpio_ps(gpio_ps), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: what the register map must hold after each clock edge.
  logic [31:0] m_out, m_dir, m_afc, m_rdata, m_ie_r, m_ie_f, m_ip;
  logic [63:0] m_pm, m_ps;
  logic        m_ack, m_err, m_irq;
  logic [31:0] hist[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 32'h0; m_dir = 32'h0; m_afc = 32'h0; m_rdata = 32'h0;
    m_ie_r = 32'h0; m_ie_f = 32'h0; m_ip = 32'h0;
    m_pm = PM_R; m_ps = PS_R; m_ack = 1'b0; m_err = 1'b0; m_irq = 1'b0;
    hist.delete();
  endtask

  function automatic logic [31:0] wr(input logic [31:0] old_v);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wdata[8*b +: 8];
    return v;
  endfunction

  // One clock edge of the register map, using the inputs present before the edge.
  task automatic model_step();
    int n;
    int w;
    logic [31:0] sync_now, bits, ier, ief, s_new, s_old;
    n = hist.size();
    sync_now = (n >= S) ? hist[n-S] : 32'h0;
    ier = m_ie_r;
    ief = m_ie_f;
    bits = 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) bits[8*b +: 8] = wdata[8*b +: 8];
    w = int'(addr[5:2]);
    m_ack = req;
    m_rdata = 32'h0;
    m_err = 1'b0;
    if (req) begin
      m_err = !((w <= 9) || (HAS_IRQ && w <= 12));
      if (!we) begin
        case (w)
          0: m_rdata = m_out;
          1: m_rdata = sync_now;
          2: m_rdata = m_dir;
          3: m_rdata = m_afc;
          4: m_rdata = m_pm[31:0];
          5: m_rdata = m_pm[63:32];
          6: m_rdata = m_ps[31:0];
          7: m_rdata = m_ps[63:32];
          10: m_rdata = HAS_IRQ ? m_ie_r : 32'h0;
          11: m_rdata = HAS_IRQ ? m_ie_f : 32'h0;
          12: m_rdata = HAS_IRQ ? m_ip : 32'h0;
          default: m_rdata = 32'h0;
        endcase
      end else begin
        case (w)
          0: m_out = wr(m_out);
          2: m_dir = wr(m_dir);
          3: m_afc = wr(m_afc);
          4: m_pm[31:0] = wr(m_pm[31:0]);
          5: m_pm[63:32] = wr(m_pm[63:32]);
          6: m_ps[31:0] = wr(m_ps[31:0]);
          7: m_ps[63:32] = wr(m_ps[63:32]);
          8: m_out = m_out | bits;
          9: m_out = m_out & ~bits;
          10: if (HAS_IRQ) m_ie_r = wr(m_ie_r);
          11: if (HAS_IRQ) m_ie_f = wr(m_ie_f);
          12: if (HAS_IRQ) m_ip = m_ip & ~bits;
          default: ;
        endcase
      end
    end
    // An edge is a change between two consecutive real pin samples seen through the synchroniser.
    if (HAS_IRQ && n >= S + 1) begin
      s_new = hist[n-S];
      s_old = hist[n-S-1];
      m_ip = m_ip | (s_new & ~s_old & ier) | (~s_new & s_old & ief);
    end
    m_irq = HAS_IRQ && (m_ip != 32'h0);
    hist.push_back(gpio_in);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) model_step();
  endtask

  task automatic bus(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    tick();
    req = 1'b0; we = 1'b0; addr = 6'h0; wdata = 32'h0; be = 4'h0;
  endtask

  // Continuous comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("gpio_out", {32'h0, gpio_out}, {32'h0, m_out});
        check("gpio_dir", {32'h0, gpio_dir}, {32'h0, m_dir});
        check("gpio_afc", {32'h0, gpio_afc}, {32'h0, m_afc});
        check("gpio_pm", gpio_pm, m_pm);
        check("gpio_ps", gpio_ps, m_ps);
        check("ack", {63'h0, ack}, {63'h0, m_ack});
        check("err", {63'h0, err}, {63'h0, m_err});
        check("rdata", {32'h0, rdata}, {32'h0, m_rdata});
        check("irq", {63'h0, irq}, {63'h0, m_irq});
      end
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 6'h0; wdata = 32'h0; be = 4'h0; gpio_in = 32'h0;
    model_reset();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_pm", gpio_pm, 64'h5555_5555_5555_5555);
    check("rst_dir", {32'h0, gpio_dir}, 64'h0);
    check("rst_ack", {63'h0, ack}, 64'h0);
    tick();
    bus(1'b0, 6'h14, 32'h0, 4'h0);
    check("rd_pm_hi", {32'h0, rdata}, 64'h5555_5555);
    bus(1'b0, 6'h1C, 32'h0, 4'hF);
    check("rd_ps_hi", {32'h0, rdata}, 64'hAAAA_0000);

    bus(1'b1, 6'h00, 32'hA5A5_0000, 4'b1100);
    check("ack_b2b_1", {63'h0, ack}, 64'h1);
    bus(1'b1, 6'h20, 32'h0000_00FF, 4'b1111);
    check("ack_b2b_2", {63'h0, ack}, 64'h1);
    bus(1'b1, 6'h24, 32'h8000_0000, 4'b1111);
    check("ack_b2b_3", {63'h0, ack}, 64'h1);
    check("out_setclr", {32'h0, gpio_out}, 64'h25A5_00FF);

    bus(1'b0, 6'h20, 32'h0, 4'hF);
    check("rd_wo_zero", {32'h0, rdata}, 64'h0);
    bus(1'b1, 6'h08, 32'hFFFF_FFFF, 4'b0000);
    check("be0_dir", {32'h0, gpio_dir}, 64'h0);
    bus(1'b1, 6'h08, 32'h1234_5678, 4'b0010);
    check("dir_byte1", {32'h0, gpio_dir}, 64'h0000_5600);
    bus(1'b1, 6'h0C, 32'hDEAD_BEEF, 4'hF);
    bus(1'b1, 6'h10, 32'h0F0F_0F0F, 4'b1001);
    bus(1'b1, 6'h1C, 32'h0000_00C3, 4'b0001);
    bus(1'b1, 6'h04, 32'hFFFF_FFFF, 4'hF);
    bus(1'b0, 6'h0C, 32'h0, 4'h0);
    bus(1'b0, 6'h10, 32'h0, 4'h0);
    check("rd_pm_lo", {32'h0, rdata}, 64'h0F55_550F);

    gpio_in = 32'h0000_0001;
    tick();
    bus(1'b0, 6'h04, 32'h0, 4'h0);
    check("in_early", {32'h0, rdata}, 64'h0);
    bus(1'b0, 6'h04, 32'h0, 4'h0);
    check("in_sync", {32'h0, rdata}, 64'h1);
    gpio_in = 32'h0;

    bus(1'b0, 6'h3C, 32'h0, 4'hF);
    check("unmapped_rd_err", {63'h0, err}, 64'h1);
    check("unmapped_rd_data", {32'h0, rdata}, 64'h0);
    bus(1'b1, 6'h3C, 32'hFFFF_FFFF, 4'hF);
    check("unmapped_wr_err", {63'h0, err}, 64'h1);
    check("unmapped_wr_out", {32'h0, gpio_out}, 64'h25A5_00FF);
    bus(1'b0, 6'h28, 32'h0, 4'hF);
    check("irq_reg_err", {63'h0, err}, HAS_IRQ ? 64'h0 : 64'h1);
    tick();

    req = 1'b1; we = 1'b1; addr = 6'h00; wdata = 32'hFFFF_FFFF; be = 4'hF;
    #2;
    rst = 1'b1;
    model_reset();
    tick();
    req = 1'b0; we = 1'b0; wdata = 32'h0; be = 4'h0;
    check("rst_mid_ack", {63'h0, ack}, 64'h0);
    check("rst_mid_out", {32'h0, gpio_out}, 64'h0);
    rst = 1'b0;
    tick();
    check("rst_mid_ack2", {63'h0, ack}, 64'h0);

`ifdef GPIO_IRQ_EN
    rst = 1'b1;
    model_reset();
    gpio_in = 32'hFFFF_FFFF;
    tick(); tick();
    rst = 1'b0;
    bus(1'b1, 6'h28, 32'hFFFF_FFFF, 4'hF);
    repeat (8) tick();
    bus(1'b0, 6'h30, 32'h0, 4'h0);
    check("no_false_rise", {32'h0, rdata}, 64'h0);
    bus(1'b1, 6'h28, 32'h0000_0008, 4'hF);
    gpio_in = 32'h0;
    repeat (4) tick();
    gpio_in = 32'h0000_0008;
    tick();
    gpio_in = 32'h0;
    tick(); tick();
    check("irq_rise", {63'h0, irq}, 64'h1);
    bus(1'b0, 6'h30, 32'h0, 4'h0);
    check("ip_rise", {32'h0, rdata}, 64'h8);
    gpio_in = 32'h0000_0008;
    tick();
    gpio_in = 32'h0;
    tick();
    bus(1'b1, 6'h30, 32'h0000_0008, 4'hF);
    bus(1'b0, 6'h30, 32'h0, 4'h0);
    check("ip_set_wins", {32'h0, rdata}, 64'h8);
    bus(1'b1, 6'h30, 32'h0000_0008, 4'hF);
    bus(1'b0, 6'h30, 32'h0, 4'h0);
    check("ip_w1c", {32'h0, rdata}, 64'h0);
    check("irq_clear", {63'h0, irq}, 64'h0);
    bus(1'b1, 6'h2C, 32'h0000_0010, 4'hF);
    gpio_in = 32'h0000_0010;
    repeat (4) tick();
    gpio_in = 32'h0;
    repeat (4) tick();
    bus(1'b0, 6'h30, 32'h0, 4'h0);
    check("ip_fall", {32'h0, rdata}, 64'h10);
`endif

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
